// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// SPI master that frames a 10-bit host command onto MOSI under SS_n. Each
// frame is a read/write header bit followed by the command word, MSB first.
// For read-data commands (cmd_word[9:8] == 2'b11) it then waits READ_GAP
// cycles and captures an 8-bit reply from MISO, MSB first.
//
// Ports:
//   clk       in   system clock (the SPI shift clock is clk itself)
//   rst_n     in   asynchronous active-low reset
//   start     in   host request strobe, only honoured while busy = 0
//   cmd_word  in   [9:8] cmd (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data),
//                  [7:0] payload
//   busy      out  transaction in progress (SELECT .. END)
//   done      out  one-cycle pulse in the END cycle of every frame
//   rd_data   out  last byte captured from MISO, held between read-data frames
//   rd_valid  out  one-cycle pulse together with done, read-data frames only
//   SS_n      out  slave select, active low
//   MOSI      out  serial data to the slave
//   MISO      in   serial data from the slave
//
// Handshake: start is a level sampled on every rising edge while the FSM is
// in IDLE. The edge that sees start = 1 accepts cmd_word, and busy rises
// in the following cycle. There is no back-pressure and no queueing, so a
// start seen while busy is dropped. done and rd_valid act as single-cycle
// valid strobes with no ready.
//
// All outputs are flops. Their next values are decoded from the next state,
// so each output lines up with the state it describes.

module spi_master_ctrl #(
   parameter int   READ_GAP     = 2,
   parameter logic DEFAULT_MOSI = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [9:0] cmd_word,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SELECT = 3'd1;
   localparam logic [2:0] ST_HEADER = 3'd2;
   localparam logic [2:0] ST_SHIFT  = 3'd3;
   localparam logic [2:0] ST_GAP    = 3'd4;
   localparam logic [2:0] ST_RECV   = 3'd5;
   localparam logic [2:0] ST_END    = 3'd6;

   localparam logic [3:0] GAP_LAST  = 4'(READ_GAP - 1);

   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [9:0] shreg_q, shreg_d;
   logic       is_rd_q, is_rd_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       ss_n_q, ss_n_d;
   logic       mosi_q, mosi_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       rd_valid_q, rd_valid_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      is_rd_d   = is_rd_q;
      rd_data_d = rd_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shreg_d = cmd_word;
               is_rd_d = (cmd_word[9:8] == 2'b11);
               cnt_d   = 4'd0;
               state_d = ST_SELECT;
            end
         end
         ST_SELECT: state_d = ST_HEADER;
         ST_HEADER: begin
            // The header is cmd_word[9] without consuming it. The first SHIFT
            // cycle sends bit 9 again, so the shift starts from here.
            shreg_d = {shreg_q[8:0], 1'b0};
            cnt_d   = 4'd0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (cnt_q == 4'd9) begin
               cnt_d   = 4'd0;
               state_d = is_rd_q ? ST_GAP : ST_END;
            end else begin
               shreg_d = {shreg_q[8:0], 1'b0};
               cnt_d   = cnt_q + 4'd1;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 4'd0;
               state_d = ST_RECV;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RECV: begin
            // The shift register is reused to assemble the reply.
            shreg_d = {shreg_q[8:0], MISO};
            if (cnt_q == 4'd7) begin
               cnt_d     = 4'd0;
               rd_data_d = {shreg_q[6:0], MISO};
               state_d   = ST_END;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_END:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered from the next state.
      ss_n_d     = !((state_d == ST_SELECT) || (state_d == ST_HEADER) ||
                     (state_d == ST_SHIFT)  || (state_d == ST_GAP)    ||
                     (state_d == ST_RECV));
      mosi_d     = ((state_d == ST_HEADER) || (state_d == ST_SHIFT)) ?
                   shreg_q[9] : DEFAULT_MOSI;
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_END);
      rd_valid_d = (state_d == ST_END) && is_rd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         shreg_q    <= 10'd0;
         is_rd_q    <= 1'b0;
         rd_data_q  <= 8'h00;
         ss_n_q     <= 1'b1;
         mosi_q     <= DEFAULT_MOSI;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         is_rd_q    <= is_rd_d;
         rd_data_q  <= rd_data_d;
         ss_n_q     <= ss_n_d;
         mosi_q     <= mosi_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign SS_n     = ss_n_q;
   assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl. Two instances are built: one with the default
// READ_GAP = 2 and one with READ_GAP = 4. They share the stimulus, and the
// sel signal chooses which instance gets start and is observed.
// The reference model describes each frame by its cycle index after the
// accepting edge:
//   cycle 1 is select, cycle 2 is the header, cycles 3..12 are cmd bits 9..0,
//   and read-data frames add a gap plus 8 reply cycles.
// Expected read bytes go through exp_q.

module tb_spi_master_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] cmd_word;
  logic       miso;
  logic       sel;

  logic       busy_a, done_a, rd_valid_a, ss_n_a, mosi_a;
  logic [7:0] rd_data_a;
  logic       busy_b, done_b, rd_valid_b, ss_n_b, mosi_b;
  logic [7:0] rd_data_b;

  logic       o_busy, o_done, o_rd_valid, o_ss_n, o_mosi;
  logic [7:0] o_rd_data;

  logic [7:0] exp_q[$];
  logic [7:0] exp_rd[2];

  int n_cmp;
  int n_bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_master_ctrl #(.READ_GAP(2), .DEFAULT_MOSI(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .cmd_word(cmd_word),
    .busy(busy_a), .done(done_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .SS_n(ss_n_a), .MOSI(mosi_a), .MISO(miso)
  );

  spi_master_ctrl #(.READ_GAP(4), .DEFAULT_MOSI(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .cmd_word(cmd_word),
    .busy(busy_b), .done(done_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(miso)
  );

  assign o_busy     = sel ? busy_b     : busy_a;
  assign o_done     = sel ? done_b     : done_a;
  assign o_rd_valid = sel ? rd_valid_b : rd_valid_a;
  assign o_ss_n     = sel ? ss_n_b     : ss_n_a;
  assign o_mosi     = sel ? mosi_b     : mosi_a;
  assign o_rd_data  = sel ? rd_data_b  : rd_data_a;

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ss_n"},     32'(o_ss_n),     32'd1);
    check({tag, "_mosi"},     32'(o_mosi),     32'd0);
    check({tag, "_busy"},     32'(o_busy),     32'd0);
    check({tag, "_done"},     32'(o_done),     32'd0);
    check({tag, "_rd_valid"}, 32'(o_rd_valid), 32'd0);
    check({tag, "_rd_data"},  32'(o_rd_data),  32'(exp_rd[sel]));
  endtask

  // ---------------- driver + model ----------------
  // Called at a negedge with the selected instance idle. The task checks
  // every cycle through the first idle cycle after done and returns at that
  // negedge, so the next call asserts start in the first idle cycle.
  task automatic run_frame(input logic [9:0] cmd, input logic [7:0] reply, input bit poke);
    int   g;
    bit   rd;
    int   last;
    int   endc;
    int   low;
    logic exp_mosi;
    g    = sel ? 4 : 2;
    rd   = (cmd[9:8] == 2'b11);
    last = rd ? 20 + g : 12;
    endc = last + 1;
    low  = 0;
    start    = 1'b1;
    cmd_word = cmd;
    if (rd) exp_q.push_back(reply);
    for (int c = 1; c <= endc + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && c == 6) begin
        start    = 1'b1;
        cmd_word = ~cmd;
      end
      exp_mosi = 1'b0;
      if (c == 2) exp_mosi = cmd[9];
      else if (c >= 3 && c <= 12) exp_mosi = cmd[12 - c];
      check("mosi",     32'(o_mosi),     32'(exp_mosi));
      check("ss_n",     32'(o_ss_n),     (c <= last) ? 32'd0 : 32'd1);
      check("busy",     32'(o_busy),     (c <= endc) ? 32'd1 : 32'd0);
      check("done",     32'(o_done),     (c == endc) ? 32'd1 : 32'd0);
      check("rd_valid", 32'(o_rd_valid), (c == endc && rd) ? 32'd1 : 32'd0);
      if (c == endc) begin
        if (rd) exp_rd[sel] = exp_q.pop_front();
        check("rd_data", 32'(o_rd_data), 32'(exp_rd[sel]));
      end
      if (o_ss_n == 1'b0) low++;
      // The reply is presented only during the receive window. Outside it
      // MISO carries junk, which must never reach rd_data.
      if (rd && c >= 13 + g && c <= 20 + g) miso = reply[20 + g - c];
      else miso = 1'($urandom_range(0, 1));
    end
    check("ss_low_len", 32'(low), 32'(last));
  endtask

  // Start a read-data frame on instance A and pull reset in the middle of
  // the reply.
  task automatic abort_in_recv(input logic [9:0] cmd);
    start    = 1'b1;
    cmd_word = cmd;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      miso  = 1'($urandom_range(0, 1));
    end
    #2 rst_n = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    #1;
    check("abort_ss_n", 32'(o_ss_n), 32'd1);
    check("abort_busy", 32'(o_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("abort_hold");
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort_after");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [9:0] rc;
    logic [7:0] rr;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    cmd_word  = 10'd0;
    miso      = 1'b0;
    sel       = 1'b0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // write address 0xA5
    run_frame(10'b00_1010_0101, 8'h00, 1'b0);
    // abort mid-reply, then a full read-data frame
    abort_in_recv(10'h3C0);
    run_frame(10'h3C0, 8'hB6, 1'b0);
    // read address immediately followed by read data
    run_frame(10'h255, 8'h00, 1'b0);
    run_frame(10'h3AA, 8'h71, 1'b0);
    // start with a different command during SHIFT must be ignored
    run_frame(10'h1C3, 8'h00, 1'b1);
    run_frame(10'h0F0, 8'h00, 1'b1);

    // READ_GAP = 4 instance
    sel = 1'b1;
    @(negedge clk);
    run_frame(10'h300, 8'h5A, 1'b0);
    run_frame(10'h2FF, 8'h00, 1'b0);

    // randomized frames on both instances
    for (int i = 0; i < 24; i++) begin
      sel = 1'($urandom_range(0, 1));
      rc  = 10'($urandom_range(0, 1023));
      if (i % 2 == 0) rc[9:8] = 2'b11;
      rr  = 8'($urandom_range(0, 255));
      run_frame(rc, rr, 1'($urandom_range(0, 1)));
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
